// File: rtl/handshake_rr_arbiter_if.sv
// Bus bundle for the round-robin arbiter: N_REQ upstream valid/ready senders
// plus one downstream valid/ready stream tagged with the source index.
interface handshake_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  localparam int SW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid_i;
  logic [N_REQ*DW-1:0] req_data_i;
  logic [N_REQ-1:0]    req_ready_o;
  logic [N_REQ-1:0]    grant_o;
  logic                m_valid_o;
  logic [DW-1:0]       m_data_o;
  logic [SW-1:0]       m_src_o;
  logic                m_ready_i;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_data_i, m_ready_i,
    output req_ready_o, grant_o, m_valid_o, m_data_o, m_src_o
  );

  // Environment side: the senders and the downstream receiver
  modport master (
    output req_valid_i, req_data_i, m_ready_i,
    input  req_ready_o, grant_o, m_valid_o, m_data_o, m_src_o
  );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one registered downstream stage among N_REQ senders.
// state | meaning
// IDLE  | no grant; pick next valid requester after last_grant (one bubble cycle)
// GRANT | one requester owns the output stage for up to MAX_BURST beats
module handshake_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  handshake_rr_arbiter_if.slave bus
);
  localparam int SW = $clog2(N_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  grant_q, grant_nxt;
  logic [SW-1:0]     gidx_q, gidx_nxt;
  logic [SW-1:0]     last_q, last_nxt;
  logic [7:0]        left_q, left_nxt;
  logic [SW-1:0]     pick;
  logic              pick_ok;
  logic              can_accept;
  logic              g_valid;
  logic [DW-1:0]     g_data;
  logic              xfer;
  logic              m_valid_q;
  logic [DW-1:0]     m_data_q;
  logic [SW-1:0]     m_src_q;

  // Scan offsets downward so the nearest requester after last_q wins.
  always_comb begin
    logic [SW-1:0] cand;
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = SW'((int'(last_q) + off) % N_REQ);
      if (bus.req_valid_i[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gidx_q == SW'(k)) g_data = bus.req_data_i[k*DW +: DW];
    end
  end

  assign can_accept = !m_valid_q || bus.m_ready_i;
  assign g_valid    = bus.req_valid_i[gidx_q];
  assign xfer       = (state == GRANT) && g_valid && can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= SW'(N_REQ - 1);
      left_q  <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      gidx_q  <= gidx_nxt;
      last_q  <= last_nxt;
      left_q  <= left_nxt;
    end
  end

  // left_q counts the beats still allowed after the current one; zero is terminal.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    gidx_nxt  = gidx_q;
    last_nxt  = last_q;
    left_nxt  = left_q;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = GRANT;
          grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          gidx_nxt  = pick;
          left_nxt  = 8'(MAX_BURST - 1);
        end
      end
      GRANT: begin
        if (!g_valid || (can_accept && left_q == 8'd0)) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = gidx_q;
        end else if (can_accept) begin
          left_nxt = left_q - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // A new beat may overwrite a beat being popped on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_src_q   <= '0;
    end else if (xfer) begin
      m_valid_q <= 1'b1;
      m_data_q  <= g_data;
      m_src_q   <= gidx_q;
    end else if (bus.m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready_o = (state == GRANT && can_accept) ? grant_q : '0;
  assign bus.grant_o     = grant_q;
  assign bus.m_valid_o   = m_valid_q;
  assign bus.m_data_o    = m_data_q;
  assign bus.m_src_o     = m_src_q;
endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready receiver among N_REQ upstream 8-bit valid/ready senders.
- Grants one requester at a time and holds the grant for a burst of up to MAX_BURST beats.
- Forwards accepted beats through one registered output stage, tagged with the source index.
- Sits between the bus senders and the Handshake receiver, which drives m_ready_i, possibly stalling at random.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width per beat.
- MAX_BURST, 4, maximum beats per grant (1..255).
- SW, $clog2(N_REQ), source-index width (derived, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_i  input  N_REQ  per-requester valid.
- req_data_i  input  N_REQ*DW  per-requester data; requester k occupies bits [k*DW +: DW].
- req_ready_o  output  N_REQ  per-requester ready; at most one bit high.
- grant_o  output  N_REQ  one-hot registered grant; all-zero when idle.
- m_valid_o  output  1  downstream valid.
- m_data_o  output  DW  downstream data.
- m_src_o  output  SW  index of the requester that sourced m_data_o.
- m_ready_i  input  1  downstream ready.

Behaviour:
- One clock domain (clk). rst_n is asynchronous, active-low. Reset takes effect immediately, independent of clk.
- Reset values:
  - state=IDLE, grant_o=0, req_ready_o=0.
  - m_valid_o=0, m_data_o=0, m_src_o=0.
  - beat count=0, last_grant=N_REQ-1, so requester 0 has first priority.
- Output stage: can_accept = !m_valid_o || m_ready_i.
- State IDLE:
  - req_ready_o=0.
  - If any req_valid_i is high, pick the first valid index searching upward from (last_grant+1) mod N_REQ, with wrap-around.
  - At the clock edge: grant_o <= one-hot(pick), count <= 0, state <= GRANT.
  - If no req_valid_i is high, stay in IDLE.
- State GRANT, granted index g:
  - req_ready_o[g] = can_accept (combinational); all other ready bits are 0.
  - A beat transfers when req_valid_i[g] && req_ready_o[g].
  - On a transfer: m_data_o <= data[g], m_src_o <= g, m_valid_o <= 1, count <= count+1.
  - If the transfer is beat number MAX_BURST: state <= IDLE, last_grant <= g, grant_o <= 0.
  - If req_valid_i[g]=0 during a GRANT cycle: release without transfer (state <= IDLE, last_grant <= g, grant_o <= 0).
  - If req_valid_i[g]=1 but can_accept=0: hold; count and grant are unchanged.
- Output stage when no beat is accepted: if m_ready_i=1, m_valid_o <= 0. Otherwise m_valid_o, m_data_o and m_src_o hold stable.
- Latency and throughput:
  - A beat accepted on edge t is visible on m_* after edge t.
  - Throughput is 1 beat/cycle inside a burst.
  - Each grant change costs exactly one IDLE bubble cycle.
- Downstream stall: while m_valid_o=1 and m_ready_i=0, m_data_o and m_src_o do not change, and no beat is lost or duplicated.
- Requesters not granted see ready=0. The arbiter never takes data from an ungranted requester.
- Same-edge events: a downstream pop (m_ready_i=1) and a new acceptance on the same edge are legal. The new beat replaces the old one, and m_valid_o stays 1.
- MAX_BURST=1: grants alternate every beat, with one bubble between grants.
- Reset mid-burst:
  - All state clears immediately, and the in-flight output beat is dropped.
  - After release, arbitration restarts with requester 0 first.

Test Plan:
- Reset: hold rst_n=0 with every req_valid_i=1 -> m_valid_o=0, req_ready_o=0000, grant_o=0000, m_src_o=0. Release reset -> first grant_o=0001.
- Single requester 2 streams 0x10..0x17 continuously, m_ready_i=1, MAX_BURST=4 ->
  - m_data_o shows 0x10,0x11,0x12,0x13 on consecutive cycles with m_src_o=2;
  - then a one-cycle bubble;
  - then 0x14..0x17 with m_src_o=2.
- All four requesters valid continuously, m_ready_i=1 ->
  - grant order 0,1,2,3,0;
  - each grant carries exactly 4 beats with matching m_src_o;
  - a one-cycle bubble separates grants.
- Backpressure: m_ready_i=0 for 3 cycles while m_valid_o=1 with data 0x21 ->
  - m_data_o stays 0x21 and req_ready_o[g]=0 for those 3 cycles;
  - after m_ready_i=1, the sequence continues 0x22 with no gaps or repeats.
- Early release: requester 1 sends 2 beats then drops valid; requester 3 is waiting and requester 2 is idle ->
  - grant moves to 3 after one IDLE cycle;
  - requester 1 re-asserting during 3's burst is granted only after 3 releases.
- Reset mid-burst: drive rst_n=0 after beat 2 of requester 2's burst while m_valid_o=1 -> m_valid_o falls at once, without waiting for clk. After release, with requesters 0 and 2 valid, grant_o=0001.
